// File: rtl/pwm_multi_db_pkg.sv
// pwm_multi_db shared types and constants.
// Default geometry of the two-motor PWM block.
package pwm_multi_db_pkg;

    localparam int PWM_WIDTH    = 11;
    localparam int PWM_NCH      = 2;
    localparam int PWM_DT_WIDTH = 6;

    localparam logic [PWM_WIDTH-1:0] CNT_MAX = '1;

    typedef logic [PWM_WIDTH-1:0]    duty_t;
    typedef logic [PWM_DT_WIDTH-1:0] dt_t;
    typedef duty_t [PWM_NCH-1:0]     duty_arr_t;

    function automatic duty_t ch_duty(input duty_arr_t d, input int c);
        return d[c];
    endfunction

endpackage

// File: rtl/pwm_multi_db_ch.sv
// pwm_db_ch: one PWM channel - raw compare flop, run-length counter
// and dead-time gated complementary high/low drive flops.
import pwm_multi_db_pkg::*;

module pwm_db_ch #(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int DT_WIDTH = PWM_DT_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic [WIDTH-1:0]    cnt_i,
    input  logic [WIDTH-1:0]    duty_i,
    input  logic [DT_WIDTH-1:0] dt_i,
    output logic                hi_o,
    output logic                lo_o
);

    localparam logic [DT_WIDTH-1:0] RUN_MAX = '1;

    logic                raw_q, raw_d;
    logic                hi_q, hi_d;
    logic                lo_q, lo_d;
    logic [DT_WIDTH-1:0] run_q, run_d;
    logic                settled;

    // Raw level, run length (saturating at the largest dead-time so a
    // dead-time increase still sees the true run) and gated drives
    always_comb begin
        raw_d   = en_i & (cnt_i < duty_i);
        settled = (run_q >= dt_i);
        hi_d    = en_i & raw_q & settled;
        lo_d    = en_i & ~raw_q & settled;
        run_d   = run_q;
        if (!en_i || (raw_d != raw_q)) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
        end
    end

    // Channel state registers; reset drops both drives at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= 1'b0;
            run_q <= '0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
        end else begin
            raw_q <= raw_d;
            run_q <= run_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/pwm_multi_db.sv
// pwm_multi_db: shared period counter and double-buffered duty and
// dead-time registers feeding one dead-time channel per motor.
import pwm_multi_db_pkg::*;

module pwm_multi_db #(
    parameter int WIDTH    = PWM_WIDTH,
    parameter int NCH      = PWM_NCH,
    parameter int DT_WIDTH = PWM_DT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH*WIDTH-1:0] duty,
    input  logic [DT_WIDTH-1:0]  dt,
    input  logic                 duty_ld,
    output logic                 duty_pend,
    output logic                 period_start,
    output logic [NCH-1:0]       pwm_hi,
    output logic [NCH-1:0]       pwm_lo
);

    localparam logic [WIDTH-1:0] LAST = '1;

    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [NCH*WIDTH-1:0] pnd_duty_q, pnd_duty_d;
    logic [NCH*WIDTH-1:0] act_duty_q, act_duty_d;
    logic [DT_WIDTH-1:0]  pnd_dt_q, pnd_dt_d;
    logic [DT_WIDTH-1:0]  act_dt_q, act_dt_d;
    logic                 pend_q, pend_d;
    logic                 bnd;

    // Counter advance; a strobe on the boundary clock goes straight
    // through to active because pending already holds it here
    always_comb begin
        cnt_d      = en ? cnt_q + 1'b1 : '0;
        bnd        = ~en | (cnt_q == LAST);
        pnd_duty_d = duty_ld ? duty : pnd_duty_q;
        pnd_dt_d   = duty_ld ? dt : pnd_dt_q;
        act_duty_d = act_duty_q;
        act_dt_d   = act_dt_q;
        pend_d     = pend_q | duty_ld;
        if (bnd) begin
            act_duty_d = pnd_duty_d;
            act_dt_d   = pnd_dt_d;
            pend_d     = 1'b0;
        end
    end

    // Period counter and double-buffer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            pnd_duty_q <= '0;
            act_duty_q <= '0;
            pnd_dt_q   <= '0;
            act_dt_q   <= '0;
            pend_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pnd_duty_q <= pnd_duty_d;
            act_duty_q <= act_duty_d;
            pnd_dt_q   <= pnd_dt_d;
            act_dt_q   <= act_dt_d;
            pend_q     <= pend_d;
        end
    end

    assign duty_pend    = pend_q;
    assign period_start = en & (cnt_q == '0);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        pwm_db_ch #(
            .WIDTH    (WIDTH),
            .DT_WIDTH (DT_WIDTH)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .cnt_i  (cnt_q),
            .duty_i (act_duty_q[c*WIDTH +: WIDTH]),
            .dt_i   (act_dt_q),
            .hi_o   (pwm_hi[c]),
            .lo_o   (pwm_lo[c])
        );
    end

endmodule
